axi_master_ctrl: RTL

Single-outstanding AXI3 master protocol engine sitting directly downstream of the core's memory arbiter. It accepts one flat single-beat read or write request at a time and drives the full AR/R/AW/W/B valid/ready handshakes. It returns read data, a one-cycle completion pulse and an error flag to the arbiter. Transfers are always single-beat (len 0, 4-byte size, FIXED burst), so no burst counting is required.

---
 rtl/axi_pkg.sv | 34 +++
 rtl/axi_master_ctrl_if.sv | 70 +++++++
 rtl/axi_master_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 definitions for the single-beat master engine.
// Holds the controller state encoding, burst/size/response codes and the default ID.
// Pure declarations: no logic, no latency, no backpressure.
package axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_DONE
   } state_t;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [2:0] SIZE_4B     = 3'b010;
   localparam logic [3:0] LEN_SINGLE  = 4'd0;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [3:0] DEFAULT_ID  = 4'b0000;

   // Anything other than OKAY is reported upstream as an error, EXOKAY included,
   // because this master never issues exclusive accesses.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_master_ctrl_if.sv
// AXI3 channel bundle (AR/R/AW/W/B) between the master engine and a slave.
// Ports: master modport drives addresses, write data and the R/B readies;
// slave modport drives the AR/AW/W readies and the R/B response channels.
interface axi_master_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // read address channel
   logic [3:0]          arid;
   logic [ADDR_W-1:0]   araddr;
   logic [3:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;
   // read data channel
   logic [3:0]          rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;
   // write address channel
   logic [3:0]          awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [3:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   // write data channel
   logic [3:0]          wid;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   // write response channel
   logic [3:0]          bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/axi_master_ctrl.sv
// Single-outstanding AXI3 master: one single-beat read or write per request, done_o pulse + err_o.
// Latency: read 3 cycles (accept -> done_o) min, write 3 min; each slave wait cycle adds one.
// Backpressure: req_ready_o only in IDLE; AXI valids are held until their handshake.
// Ports: clk/rst (sync, active-low); req_* request from the arbiter; done_o/err_o/rdata_o
// completion back to it; axi = master side of the AXI3 channel bundle.
module axi_master_ctrl
   import axi_pkg::*;
#(
   parameter int          ADDR_W = 32,
   parameter int          DATA_W = 32,
   parameter logic [3:0]  ID_VAL = DEFAULT_ID
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_write_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   input  logic [DATA_W/8-1:0] req_wstrb_i,
   output logic                done_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                err_o,
   axi_master_ctrl_if.master   axi
);

   localparam int STRB_W = DATA_W / 8;

   state_t              state_q,  state_d;
   logic [ADDR_W-1:0]   addr_q,   addr_d;
   logic [DATA_W-1:0]   wdata_q,  wdata_d;
   logic [STRB_W-1:0]   wstrb_q,  wstrb_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q,  w_done_d;
   logic [DATA_W-1:0]   rdata_q,  rdata_d;
   logic                err_q,    err_d;

   // Response ID and RLAST carry no information for a single-outstanding,
   // single-beat master, so they are deliberately dropped here.
   logic unused_resp_fields;
   assign unused_resp_fields = ^{axi.rid, axi.bid, axi.rlast};

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      err_d     = err_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               addr_d    = req_addr_i;
               wdata_d   = req_wdata_i;
               wstrb_d   = req_wstrb_i;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = req_write_i ? ST_WR_REQ : ST_RD_ADDR;
            end
         end
         ST_RD_ADDR: begin
            if (axi.arready) state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            if (axi.rvalid) begin
               rdata_d = axi.rdata;
               err_d   = resp_is_err(axi.rresp);
               state_d = ST_DONE;
            end
         end
         ST_WR_REQ: begin
            // AW and W complete independently; a ready seen after the channel's
            // own handshake only re-sets an already-set flag.
            if (axi.awready) aw_done_d = 1'b1;
            if (axi.wready)  w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (axi.bvalid) begin
               err_d   = resp_is_err(axi.bresp);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // All handshake outputs decode flops only, so no AXI input reaches an AXI output.
   assign req_ready_o = (state_q == ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;

   assign axi.arid    = ID_VAL;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = LEN_SINGLE;
   assign axi.arsize  = SIZE_4B;
   assign axi.arburst = BURST_FIXED;
   assign axi.arvalid = (state_q == ST_RD_ADDR);

   assign axi.rready  = (state_q == ST_RD_DATA);

   assign axi.awid    = ID_VAL;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = LEN_SINGLE;
   assign axi.awsize  = SIZE_4B;
   assign axi.awburst = BURST_FIXED;
   assign axi.awvalid = (state_q == ST_WR_REQ) && !aw_done_q;

   assign axi.wid     = ID_VAL;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
   assign axi.wlast   = axi.wvalid;

   assign axi.bready  = (state_q == ST_WR_RESP);

endmodule
